// File: rtl/autosym_pkg.sv
// Shared types for the autosymmetric PLA evaluator: FSM states, config targets,
// cube record and a constant clog2 helper.
package autosym_pkg;

  // Cube records are sized for the widest supported instance; unused high bits stay zero.
  localparam int AS_MAX_K = 32;
  localparam int AS_MAX_M = 8;

  typedef enum logic [1:0] {IDLE, PROJ, SCAN, DONE} state_e;

  localparam logic [1:0] CFG_CUBE = 2'd0;
  localparam logic [1:0] CFG_PROJ = 2'd1;
  localparam logic [1:0] CFG_CNT  = 2'd2;

  typedef struct packed {
    logic [AS_MAX_K-1:0] care;
    logic [AS_MAX_K-1:0] val;
    logic [AS_MAX_M-1:0] out;
  } cube_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/autosym_pla_eval_if.sv
// Input/output valid-ready handshakes of the PLA evaluator.
interface autosym_pla_eval_if #(
  parameter int N_IN  = 15,
  parameter int M_OUT = 1
);
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_x;
  logic             out_valid;
  logic             out_ready;
  logic [M_OUT-1:0] out_y;

  modport master (output in_valid, in_x, out_ready, input in_ready, out_valid, out_y);
  modport slave  (input in_valid, in_x, out_ready, output in_ready, out_valid, out_y);
endinterface

// File: rtl/autosym_cube_match.sv
// Combinational match of P cubes against z; returns the OR of out fields of
// every enabled cube whose cared literals all agree with z.
module autosym_cube_match
  import autosym_pkg::*;
#(
  parameter int K = 8,
  parameter int P = 1
) (
  input  logic [K-1:0]        z,
  input  cube_t [P-1:0]       cubes,
  input  logic [P-1:0]        en,
  output logic [AS_MAX_M-1:0] hit
);
  logic [AS_MAX_K-1:0]         z_ext;
  logic [P-1:0][AS_MAX_M-1:0]  lane_out;

  assign z_ext = AS_MAX_K'(z);

  for (genvar p = 0; p < P; p++) begin : g_lane
    assign lane_out[p] = (en[p] && (((z_ext ^ cubes[p].val) & cubes[p].care) == '0))
                         ? cubes[p].out : '0;
  end

  always_comb begin
    hit = '0;
    for (int p = 0; p < P; p++) hit = hit | lane_out[p];
  end
endmodule

// File: rtl/autosym_pla_eval.sv
// Sequential evaluator y = f_r(A*x): GF(2) projection then a P-cubes-per-cycle SOP scan.
// Build option AUTOSYM_PROJ_EN: programmable projection rows; otherwise z = x[K-1:0].
module autosym_pla_eval
  import autosym_pkg::*;
#(
  parameter int N_IN          = 15,
  parameter int K             = 8,
  parameter int M_OUT         = 1,
  parameter int N_CUBES       = 64,
  parameter int CUBES_PER_CYC = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [1:0]                 cfg_sel,
  input  logic [clog2(N_CUBES)-1:0]  cfg_addr,
  input  logic [K-1:0]               cfg_care,
  input  logic [K-1:0]               cfg_val,
  input  logic [M_OUT-1:0]           cfg_out,
  input  logic [clog2(N_CUBES):0]    cfg_cnt,
  output logic                       cfg_err,
  autosym_pla_eval_if.slave          io
);
  localparam int AW = clog2(N_CUBES);
  localparam int CW = AW + 1;
  localparam int P  = CUBES_PER_CYC;
  // Lanes above M_OUT are forced to one so the early-exit test only sees real outputs.
  localparam logic [AS_MAX_M-1:0] OUT_MASK = {AS_MAX_M{1'b1}} >> (AS_MAX_M - M_OUT);

`ifdef AUTOSYM_PROJ_EN
  localparam int XW = N_IN;
  localparam int KA = clog2(K);
`else
  localparam int XW = K;
`endif

  state_e              state_q, state_d;
  logic [CW-1:0]       n_active_q, n_active_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [M_OUT-1:0]    acc_q, acc_d;
  logic [K-1:0]        z_q, z_d, proj_z;
  logic [XW-1:0]       x_q, x_d;
  logic                cfg_err_q, cfg_err_d;
  logic                cfg_ok, cube_we, cnt_we, proj_legal;
  cube_t               cube_mem [N_CUBES];
  cube_t [P-1:0]       lane_cube;
  logic  [P-1:0]       lane_en;
  logic [AS_MAX_M-1:0] hit, acc_wide;
  logic                scan_full, scan_end;

`ifdef AUTOSYM_PROJ_EN
  logic [N_IN-1:0] proj_mem [K];
  logic            proj_we;

  // Rows beyond K have no storage, so such writes are rejected like an illegal target.
  assign proj_legal = (cfg_sel == CFG_PROJ) && (int'(cfg_addr) < K);
  assign proj_we    = cfg_ok && (cfg_sel == CFG_PROJ);

  always_comb begin
    proj_z = '0;
    for (int k = 0; k < K; k++) proj_z[k] = ^(proj_mem[k] & x_q);
  end

  always_ff @(posedge clk) begin
    if (proj_we) proj_mem[cfg_addr[KA-1:0]] <= N_IN'({cfg_care, cfg_val, cfg_out});
  end
`else
  assign proj_legal = 1'b0;
  assign proj_z     = x_q;
`endif

  // Configuration only lands while idle so an evaluation never sees a half-written table.
  always_comb begin
    cfg_ok    = cfg_we && (state_q == IDLE) &&
                ((cfg_sel == CFG_CUBE) || (cfg_sel == CFG_CNT) || proj_legal);
    cfg_err_d = cfg_we && !cfg_ok;
    cube_we   = cfg_ok && (cfg_sel == CFG_CUBE);
    cnt_we    = cfg_ok && (cfg_sel == CFG_CNT);
    n_active_d = n_active_q;
    if (cnt_we) n_active_d = (cfg_cnt > CW'(N_CUBES)) ? CW'(N_CUBES) : cfg_cnt;
  end

  always_comb begin
    for (int j = 0; j < P; j++) begin
      lane_cube[j] = cube_mem[idx_q[AW-1:0] + AW'(j)];
      lane_en[j]   = (idx_q + CW'(j)) < n_active_q;
    end
  end

  autosym_cube_match #(.K(K), .P(P)) u_match (
    .z     (z_q),
    .cubes (lane_cube),
    .en    (lane_en),
    .hit   (hit)
  );

  assign acc_wide  = AS_MAX_M'(acc_q) | hit;
  assign scan_full = &(acc_wide | ~OUT_MASK);
  assign scan_end  = ({1'b0, idx_q} + (CW+1)'(P)) >= {1'b0, n_active_q};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    z_d     = z_q;
    x_d     = x_q;
    case (state_q)
      IDLE: if (io.in_valid) begin
        x_d     = io.in_x[XW-1:0];
        state_d = PROJ;
      end
      PROJ: begin
        z_d     = proj_z;
        acc_d   = '0;
        idx_d   = '0;
        state_d = (n_active_q == '0) ? DONE : SCAN;
      end
      SCAN: begin
        acc_d = acc_wide[M_OUT-1:0];
        if (scan_end || scan_full) state_d = DONE;
        else                       idx_d   = idx_q + CW'(P);
      end
      DONE: if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_active_q <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_active_q <= n_active_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q <= x_d;
    z_q <= z_d;
    if (cube_we)
      cube_mem[cfg_addr] <= '{care: AS_MAX_K'(cfg_care), val: AS_MAX_K'(cfg_val),
                              out: AS_MAX_M'(cfg_out)};
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.out_y     = acc_q;
  assign cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_autosym_pla_eval.sv
// Directed bench for autosym_pla_eval with K=4, M_OUT=2, 16 cubes, one cube per cycle.
module tb_autosym_pla_eval;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [3:0] cfg_addr;
  logic [3:0] cfg_care, cfg_val;
  logic [1:0] cfg_out;
  logic [4:0] cfg_cnt;
  logic       cfg_err;
  int         errors = 0;
  int         checks = 0;

  autosym_pla_eval_if #(.N_IN(15), .M_OUT(2)) io ();

  autosym_pla_eval #(.N_IN(15), .K(4), .M_OUT(2), .N_CUBES(16), .CUBES_PER_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_out(cfg_out), .cfg_cnt(cfg_cnt),
    .cfg_err(cfg_err), .io(io)
  );

  always #5 clk = ~clk;

  task automatic cfg_wr(input logic [1:0] sel, input logic [3:0] addr, input logic [3:0] care,
                        input logic [3:0] val, input logic [1:0] out, input logic [4:0] cnt,
                        output logic err);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr;
    cfg_care = care; cfg_val = val; cfg_out = out; cfg_cnt = cnt;
    @(negedge clk);
    cfg_we = 1'b0;
    err = cfg_err;
  endtask

  task automatic set_cube(input logic [3:0] a, input logic [3:0] care, input logic [3:0] val,
                          input logic [1:0] out);
    logic e;
    cfg_wr(2'd0, a, care, val, out, 5'd0, e);
  endtask

  task automatic set_cnt(input logic [4:0] n);
    logic e;
    cfg_wr(2'd2, 4'd0, 4'd0, 4'd0, 2'd0, n, e);
  endtask

  task automatic set_row(input logic [3:0] r, input logic [9:0] bits, output logic err);
    logic [3:0] c, v;
    logic [1:0] o;
    {c, v, o} = bits;
    cfg_wr(2'd1, r, c, v, o, 5'd0, err);
  endtask

  // Latency counts clock edges from the accepting edge to the edge that sees out_valid.
  task automatic eval(input logic [14:0] x, output logic [1:0] y, output int lat);
    int n;
    @(negedge clk);
    io.in_valid = 1'b1; io.in_x = x;
    n = 0;
    while (!io.in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    lat = 1;
    while (!io.out_valid && lat < 200) begin @(negedge clk); lat++; end
    y = io.out_y;
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", io.in_ready); end
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", io.out_valid); end
    checks++; if (io.out_y !== 2'b00) begin errors++; $display("FAIL rst_out_y: got %b want 00", io.out_y); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end
  endtask

  task automatic test_identity;
    logic [1:0] y; int lat;
    set_cube(4'd0, 4'b1111, 4'b1010, 2'b01);
    set_cnt(5'd1);
    eval(15'h000A, y, lat);
    checks++; if (y !== 2'b01) begin errors++; $display("FAIL ident_hit_y: got %b want 01", y); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL ident_hit_lat: got %0d want 3", lat); end
    eval(15'h000B, y, lat);
    checks++; if (y !== 2'b00) begin errors++; $display("FAIL ident_miss_y: got %b want 00", y); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL ident_miss_lat: got %0d want 3", lat); end
  endtask

  task automatic test_zero_active;
    logic [1:0] y; int lat;
    set_cnt(5'd0);
    eval(15'h000A, y, lat);
    checks++; if (y !== 2'b00) begin errors++; $display("FAIL zero_y: got %b want 00", y); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL zero_lat: got %0d want 2", lat); end
  endtask

  task automatic test_early_exit;
    logic [1:0] y; int lat;
    set_cube(4'd0, 4'b0000, 4'b0000, 2'b11);
    set_cnt(5'd8);
    eval(15'h0000, y, lat);
    checks++; if (y !== 2'b11) begin errors++; $display("FAIL early_y: got %b want 11", y); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL early_lat: got %0d want 3", lat); end
    set_cube(4'd0, 4'b0000, 4'b0000, 2'b01);
    eval(15'h0000, y, lat);
    checks++; if (y !== 2'b01) begin errors++; $display("FAIL full_scan_y: got %b want 01", y); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL full_scan_lat: got %0d want 10", lat); end
  endtask

  task automatic test_saturate;
    logic [1:0] y; int lat; logic e;
    set_cube(4'd0, 4'b1111, 4'b1111, 2'b00);
    set_cnt(5'd20);
    eval(15'h0000, y, lat);
    checks++; if (y !== 2'b00) begin errors++; $display("FAIL sat_y: got %b want 00", y); end
    checks++; if (lat !== 18) begin errors++; $display("FAIL sat_lat: got %0d want 18", lat); end
    cfg_wr(2'd3, 4'd0, 4'd0, 4'd0, 2'd0, 5'd0, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL sel3_err: got %b want 1", e); end
  endtask

  task automatic test_proj;
    logic [1:0] y; int lat; logic e;
    logic       exp_e;
    logic [1:0] exp_y21;
`ifdef AUTOSYM_PROJ_EN
    exp_e = 1'b0; exp_y21 = 2'b00;
`else
    exp_e = 1'b1; exp_y21 = 2'b01;
`endif
    set_cube(4'd0, 4'b0001, 4'b0001, 2'b01);
    set_cnt(5'd1);
    set_row(4'd0, 10'h021, e);
    checks++; if (e !== exp_e) begin errors++; $display("FAIL proj_wr_err: got %b want %b", e, exp_e); end
    eval(15'h0021, y, lat);
    checks++; if (y !== exp_y21) begin errors++; $display("FAIL proj_x21_y: got %b want %b", y, exp_y21); end
    eval(15'h0001, y, lat);
    checks++; if (y !== 2'b01) begin errors++; $display("FAIL proj_x01_y: got %b want 01", y); end
`ifdef AUTOSYM_PROJ_EN
    set_row(4'd0, 10'h001, e);
`endif
  endtask

  task automatic test_hold;
    logic [1:0] y; int lat; int n;
    set_cube(4'd0, 4'b1111, 4'b1010, 2'b01);
    set_cnt(5'd1);
    @(negedge clk);
    io.in_valid = 1'b1; io.in_x = 15'h000A;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    n = 0;
    while (!io.out_valid && n < 50) begin @(negedge clk); n++; end
    checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_seen: got %b want 1", io.out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cfg_we = (i == 1);
      cfg_sel = 2'd0; cfg_addr = 4'd0; cfg_care = 4'b1111; cfg_val = 4'b1011; cfg_out = 2'b01;
      if (i == 2) begin
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL hold_cfg_err: got %b want 1", cfg_err); end
      end
      checks++; if (io.out_y !== 2'b01) begin errors++; $display("FAIL hold_y[%0d]: got %b want 01", i, io.out_y); end
      checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, io.in_ready); end
    end
    cfg_we = 1'b0;
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL hold_err_pulse: got %b want 0", cfg_err); end
    eval(15'h000A, y, lat);
    checks++; if (y !== 2'b01) begin errors++; $display("FAIL hold_keep_a: got %b want 01", y); end
    eval(15'h000B, y, lat);
    checks++; if (y !== 2'b00) begin errors++; $display("FAIL hold_keep_b: got %b want 00", y); end
  endtask

  task automatic test_reset_mid;
    logic [1:0] y; int lat;
    set_cube(4'd0, 4'b1111, 4'b1111, 2'b00);
    set_cnt(5'd16);
    @(negedge clk);
    io.in_valid = 1'b1; io.in_x = 15'h0000;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", io.out_valid); end
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", io.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    eval(15'h0000, y, lat);
    checks++; if (y !== 2'b00) begin errors++; $display("FAIL midrst_next_y: got %b want 00", y); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL midrst_next_lat: got %0d want 2", lat); end
  endtask

  initial begin
    logic e;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0;
    cfg_care = '0; cfg_val = '0; cfg_out = '0; cfg_cnt = '0;
    io.in_valid = 1'b0; io.in_x = '0; io.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) set_cube(4'(a), 4'b1111, 4'b1111, 2'b00);
`ifdef AUTOSYM_PROJ_EN
    for (int r = 0; r < 4; r++) set_row(4'(r), 10'(1 << r), e);
`endif
    test_identity;
    test_zero_active;
    test_early_exit;
    test_saturate;
    test_proj;
    test_hold;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
